// File: rtl/cla_pipe_adder.sv
// Three-stage pipelined two-level carry-lookahead adder with valid/ready flow control.
// Optional subtract mode is enabled by defining CLA_PIPE_SUB_EN (adds the sub input).
module cla_pipe_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CLA_PIPE_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             grp_g,
    output logic             grp_p
);

    localparam int N = WIDTH / 4;

    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

`ifdef CLA_PIPE_SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub | cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic [WIDTH-1:0] g1_q, g1_d, p1_q, p1_d;
    logic             c01_q, c01_d;
    logic [WIDTH-1:0] p2_q, p2_d;
    logic [WIDTH:0]   c2_q, c2_d;
    logic             gg2_q, gg2_d, gp2_q, gp2_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d, ovf_q, ovf_d, grp_g_q, grp_g_d, grp_p_q, grp_p_d;

    // A stage may load when its successor is empty or draining this cycle.
    logic s1_free, s2_free, s3_free;
    assign s3_free  = !v3_q || out_ready;
    assign s2_free  = !v2_q || s3_free;
    assign s1_free  = !v1_q || s2_free;
    assign in_ready = s1_free;

    logic [N-1:0]   grp_gen, grp_prop;
    logic [N:0]     grp_c, blk_c;
    logic [WIDTH:0] carry;

    assign grp_c[0] = c01_q;
    assign blk_c[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_group
            localparam int B = 4 * gi;
            assign grp_gen[gi]  = g1_q[B+3]
                                | (p1_q[B+3] & g1_q[B+2])
                                | (p1_q[B+3] & p1_q[B+2] & g1_q[B+1])
                                | (p1_q[B+3] & p1_q[B+2] & p1_q[B+1] & g1_q[B]);
            assign grp_prop[gi] = &p1_q[B+3:B];
            assign grp_c[gi+1]  = grp_gen[gi] | (grp_prop[gi] & grp_c[gi]);
            // blk_c is the same chain with zero carry-in: the exported block generate.
            assign blk_c[gi+1]  = grp_gen[gi] | (grp_prop[gi] & blk_c[gi]);
            assign carry[B]     = grp_c[gi];
            assign carry[B+1]   = g1_q[B] | (p1_q[B] & grp_c[gi]);
            assign carry[B+2]   = g1_q[B+1]
                                | (p1_q[B+1] & g1_q[B])
                                | (p1_q[B+1] & p1_q[B] & grp_c[gi]);
            assign carry[B+3]   = g1_q[B+2]
                                | (p1_q[B+2] & g1_q[B+1])
                                | (p1_q[B+2] & p1_q[B+1] & g1_q[B])
                                | (p1_q[B+2] & p1_q[B+1] & p1_q[B] & grp_c[gi]);
        end
    endgenerate

    assign carry[WIDTH] = grp_c[N];

    always_comb begin
        v1_d    = v1_q;
        g1_d    = g1_q;
        p1_d    = p1_q;
        c01_d   = c01_q;
        v2_d    = v2_q;
        p2_d    = p2_q;
        c2_d    = c2_q;
        gg2_d   = gg2_q;
        gp2_d   = gp2_q;
        v3_d    = v3_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        grp_g_d = grp_g_q;
        grp_p_d = grp_p_q;
        if (s1_free) begin
            v1_d = in_valid;
            if (in_valid) begin
                g1_d  = a & b_eff;
                p1_d  = a ^ b_eff;
                c01_d = cin_eff;
            end
        end
        if (s2_free) begin
            v2_d = v1_q;
            if (v1_q) begin
                p2_d  = p1_q;
                c2_d  = carry;
                gg2_d = blk_c[N];
                gp2_d = &p1_q;
            end
        end
        // Result registers only change on a real load so idle outputs keep the last result.
        if (s3_free) begin
            v3_d = v2_q;
            if (v2_q) begin
                sum_d   = p2_q ^ c2_q[WIDTH-1:0];
                cout_d  = c2_q[WIDTH];
                ovf_d   = c2_q[WIDTH-1] ^ c2_q[WIDTH];
                grp_g_d = gg2_q;
                grp_p_d = gp2_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            g1_q    <= '0;
            p1_q    <= '0;
            c01_q   <= 1'b0;
            v2_q    <= 1'b0;
            p2_q    <= '0;
            c2_q    <= '0;
            gg2_q   <= 1'b0;
            gp2_q   <= 1'b0;
            v3_q    <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            grp_g_q <= 1'b0;
            grp_p_q <= 1'b0;
        end else begin
            v1_q    <= v1_d;
            g1_q    <= g1_d;
            p1_q    <= p1_d;
            c01_q   <= c01_d;
            v2_q    <= v2_d;
            p2_q    <= p2_d;
            c2_q    <= c2_d;
            gg2_q   <= gg2_d;
            gp2_q   <= gp2_d;
            v3_q    <= v3_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            grp_g_q <= grp_g_d;
            grp_p_q <= grp_p_d;
        end
    end

    assign out_valid = v3_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign grp_g     = grp_g_q;
    assign grp_p     = grp_p_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder: directed corner cases, stall/backpressure,
// mid-flight reset and randomized traffic against an arithmetic reference model.
module tb_cla_pipe_adder;
    localparam int W = 16;
    typedef logic [W+3:0] res_t;  // {sum, cout, ovf, grp_g, grp_p}

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, cin, out_valid, out_ready;
    logic         cout, ovf, grp_g, grp_p;
    logic [W-1:0] a, b, sum;
`ifdef CLA_PIPE_SUB_EN
    logic         sub;
`endif

    int   pass_cnt = 0;
    int   chk_cnt  = 0;
    res_t exp_q[$];
    res_t last_out, stall_val;
    bit   have_last  = 1'b0;
    bit   prev_stall = 1'b0;

    always #5 clk = ~clk;

    cla_pipe_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
`ifdef CLA_PIPE_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
        .ovf(ovf), .grp_g(grp_g), .grp_p(grp_p)
    );

    // Reference: plain integer addition; block G is the carry out with zero carry-in.
    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        logic [W:0]   full, gen;
        logic [W-1:0] s;
        logic         v;
        full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        gen  = {1'b0, x} + {1'b0, y};
        s    = full[W-1:0];
        v    = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
        return {s, full[W], v, gen[W], &(x ^ y)};
    endfunction

    function automatic res_t model_in();
        logic [W-1:0] y;
        logic         c;
        y = b;
        c = cin;
`ifdef CLA_PIPE_SUB_EN
        if (sub) begin
            y = ~b;
            c = 1'b1;
        end
`endif
        return model(a, y, c);
    endfunction

    function automatic res_t obs();
        return {sum, cout, ovf, grp_g, grp_p};
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return 16'hFFFF;
            1:       return 16'h7FFF;
            2:       return 16'h8000;
            3:       return 16'h0000;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
        chk_cnt++;
        assert (o === e) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, o, e);
    endtask

    // One clock cycle of traffic: sample at negedge, score outputs, record accepted inputs.
    task automatic step(output bit acc);
        res_t e;
        @(negedge clk);
        if (prev_stall) check("stall_hold", obs(), stall_val);
        else if (!out_valid && have_last) check("idle_hold", obs(), last_out);
        acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("spurious_out", out_valid, 1'b0);
            else begin
                e = exp_q.pop_front();
                check("result", obs(), e);
                $display("out: sum=%h cout=%b ovf=%b grp_g=%b grp_p=%b", sum, cout, ovf, grp_g, grp_p);
            end
            last_out  = obs();
            have_last = 1'b1;
        end
        prev_stall = out_valid && !out_ready;
        stall_val  = obs();
        if (acc) exp_q.push_back(model_in());
        @(posedge clk);
        #1;
    endtask

    // Single op through an empty pipe: latency counted in edges including the accepting one.
    task automatic run_single(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                              input logic c, input bit s, input res_t e);
        int lat;
        a = x; b = y; cin = c; in_valid = 1'b1; out_ready = 1'b1;
`ifdef CLA_PIPE_SUB_EN
        sub = s;
`endif
        @(negedge clk);
        check({tag, "_in_ready"}, in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, lat, 3);
        check({tag, "_result"}, obs(), e);
        $display("%s: a=%h b=%h cin=%b s=%b -> sum=%h cout=%b ovf=%b grp_g=%b grp_p=%b",
                 tag, x, y, c, s, sum, cout, ovf, grp_g, grp_p);
        last_out   = e;
        have_last  = 1'b1;
        prev_stall = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit acc;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 30 && exp_q.size() > 0; i++) step(acc);
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc, done, seen_block;
        int cyc, n_acc;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
`ifdef CLA_PIPE_SUB_EN
        sub = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_outputs", obs(), '0);
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1'b1);

        run_single("add_00ff", 16'h00FF, 16'h0001, 1'b0, 1'b0, {16'h0100, 4'b0000});
        run_single("ripple",   16'hFFFF, 16'h0000, 1'b1, 1'b0, {16'h0000, 4'b1001});
        run_single("ovf",      16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h8000, 4'b0100});

        // Eight back-to-back ops with the consumer stalled for cycles 2-4.
        n_acc = 0; seen_block = 1'b0; cyc = 0;
        in_valid = 1'b1; a = pick(); b = pick(); cin = 1'($urandom_range(0, 1));
        while (n_acc < 8 && cyc < 40) begin
            out_ready = !(cyc >= 2 && cyc <= 4);
            if (in_valid && !in_ready) seen_block = 1'b1;
            step(acc);
            cyc++;
            if (acc) begin
                n_acc++;
                a = pick(); b = pick(); cin = 1'($urandom_range(0, 1));
                in_valid = (n_acc < 8);
            end
        end
        check("burst_accepted", n_acc, 8);
        check("in_ready_drop", seen_block, 1'b1);
        drain();

        // Randomized traffic with random backpressure; producer holds until accepted.
        done = 1'b1;
        for (int i = 0; i < 150; i++) begin
            if (done) begin
                in_valid = ($urandom_range(0, 3) != 0);
                a = pick(); b = pick(); cin = 1'($urandom_range(0, 1));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            step(acc);
            done = acc || !in_valid;
        end
        drain();

        // Reset with three ops in flight.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = pick(); b = pick(); cin = 1'($urandom_range(0, 1));
            step(acc);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_outputs", obs(), '0);
        exp_q.delete();
        prev_stall = 1'b0;
        last_out   = '0;
        have_last  = 1'b1;
        for (int i = 0; i < 6; i++) step(acc);
        run_single("post_rst", 16'h1357, 16'h2468, 1'b1, 1'b0, model(16'h1357, 16'h2468, 1'b1));

`ifdef CLA_PIPE_SUB_EN
        run_single("sub_5_7", 16'h0005, 16'h0007, 1'b0, 1'b1, {16'hFFFE, 4'b0000});
        run_single("sub_eq",  16'h1234, 16'h1234, 1'b0, 1'b1, {16'h0000, 4'b1001});
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
